// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the bubble word, fetch state encodings and default address map.
package instr_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR_DEF      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF       = 32'd0;
    localparam logic [31:0] IMEM_LAST_ADDR_DEF = 32'd84;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_LOAD   = 2'd2
    } ifid_op_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_next_pc.sv
// Combinational next-pc / next-state selector for the fetch stage.
// state    | meaning
// ST_RUN   | fetching sequentially, honours branch/stall/flush
// ST_HALT  | pc ran past the last instruction, waits for a redirect
// ST_FAULT | misaligned redirect seen, frozen until reset
module fetch_next_pc
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] IMEM_LAST_ADDR = IMEM_LAST_ADDR_DEF
) (
    input  fetch_state_e state_q,
    input  logic [31:0]  pc_q,
    input  logic         stall,
    input  logic         flush,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output fetch_state_e state_d,
    output logic [31:0]  pc_d,
    output ifid_op_e     ifid_op
);

    logic [31:0] pc_plus4;
    logic        target_ok;

    assign pc_plus4  = pc_q + 32'd4;
    assign target_ok = is_word_aligned(branch_target);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_op = IFID_BUBBLE;

        unique case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    if (!target_ok) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = branch_target;
                    end
                end else if (stall) begin
                    ifid_op = flush ? IFID_BUBBLE : IFID_HOLD;
                end else begin
                    pc_d    = pc_plus4;
                    ifid_op = flush ? IFID_BUBBLE : IFID_LOAD;
                end
                // Halt decision uses the updated pc, so the last word is still captured.
                if (state_d == ST_RUN && pc_d > IMEM_LAST_ADDR) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (branch_taken && target_ok && branch_target <= IMEM_LAST_ADDR) begin
                    pc_d    = branch_target;
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, drives the instruction memory address and
// captures the returned word into the IF/ID register.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEF,
    parameter logic [31:0] IMEM_LAST_ADDR = IMEM_LAST_ADDR_DEF,
    parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        halted,
    output logic        fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    ifid_op_e     ifid_op;
    logic [31:0]  ifid_pc_q, ifid_instr_q;
    logic         ifid_valid_q;

    fetch_next_pc #(
        .IMEM_LAST_ADDR (IMEM_LAST_ADDR)
    ) u_next_pc (
        .state_q       (state_q),
        .pc_q          (pc_q),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .state_d       (state_d),
        .pc_d          (pc_d),
        .ifid_op       (ifid_op)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            unique case (ifid_op)
                IFID_LOAD: begin
                    ifid_pc_q    <= pc_q;
                    ifid_instr_q <= imem_instr;
                    ifid_valid_q <= 1'b1;
                end
                IFID_BUBBLE: begin
                    ifid_pc_q    <= pc_q;
                    ifid_instr_q <= NOP_INSTR;
                    ifid_valid_q <= 1'b0;
                end
                default: begin
                    ifid_pc_q    <= ifid_pc_q;
                    ifid_instr_q <= ifid_instr_q;
                    ifid_valid_q <= ifid_valid_q;
                end
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;
    assign halted     = (state_q == ST_HALT);
    assign fault      = (state_q == ST_FAULT);

endmodule
